// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - SPI slave: 2-bit command + DATA_W payload frames, read-address/read-data readout.
// Optional odd-parity bit after the frame when SPI_SLAVE_PARITY_EN is defined.
module spi_slave_param #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int TXC_W   = $clog2(DATA_W + 2);
`ifdef SPI_SLAVE_PARITY_EN
  localparam int DONE_CNT = FRAME_W;
  localparam int SHIFT_W  = FRAME_W;
`else
  localparam int DONE_CNT = FRAME_W - 1;
  localparam int SHIFT_W  = FRAME_W - 1;
`endif

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [SHIFT_W-1:0]  shift_q;
  logic [FRAME_W-1:0]  rx_data_q;
  logic                rx_valid_q;
  logic                frame_err_q;
  logic                miso_q;
  logic                rd_addr_flag;
  logic [DATA_W-1:0]   tx_shift;
  // 0: awaiting tx_valid, 1..DATA_W: bits driven, DATA_W+1: readout finished
  logic [TXC_W-1:0]    tx_cnt;
`ifdef SPI_SLAVE_PARITY_EN
  logic                parity_err_q;
`endif
  logic                frame_done;
  logic                rd_pending;

  assign frame_done = (cnt == CNT_W'(DONE_CNT));
  assign rd_pending = (state == READ_DATA) && (tx_cnt < TXC_W'(DATA_W));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!SS_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              state_nxt = IDLE;
        else if (!MOSI)        state_nxt = WRITE;
        else if (rd_addr_flag) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      default: if (SS_n) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    MISO      = miso_q;
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    frame_err = frame_err_q;
`ifdef SPI_SLAVE_PARITY_EN
    parity_err = parity_err_q;
`else
    parity_err = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      miso_q       <= 1'b0;
      rd_addr_flag <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
`ifdef SPI_SLAVE_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt    <= '0;
          tx_cnt <= '0;
          miso_q <= 1'b0;
        end
        CHK_CMD: begin
          cnt    <= '0;
          tx_cnt <= '0;
          miso_q <= 1'b0;
          if (SS_n) frame_err_q <= 1'b1;
          else      shift_q <= {shift_q[SHIFT_W-2:0], MOSI};
        end
        default: begin
          if (SS_n) begin
            miso_q <= 1'b0;
            if (!frame_done || rd_pending) frame_err_q <= 1'b1;
          end else if (!frame_done) begin
            cnt <= cnt + CNT_W'(1);
`ifdef SPI_SLAVE_PARITY_EN
            if (cnt == CNT_W'(FRAME_W - 1)) begin
              if (^{shift_q, MOSI}) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
                if (state == READ_ADD)       rd_addr_flag <= 1'b1;
                else if (state == READ_DATA) rd_addr_flag <= 1'b0;
              end else begin
                parity_err_q <= 1'b1;
              end
            end else begin
              shift_q <= {shift_q[SHIFT_W-2:0], MOSI};
            end
`else
            shift_q <= {shift_q[SHIFT_W-2:0], MOSI};
            if (cnt == CNT_W'(FRAME_W - 2)) begin
              rx_data_q  <= {shift_q, MOSI};
              rx_valid_q <= 1'b1;
              if (state == READ_ADD)       rd_addr_flag <= 1'b1;
              else if (state == READ_DATA) rd_addr_flag <= 1'b0;
            end
`endif
          end else if (state == READ_DATA) begin
            if (tx_cnt == '0) begin
              if (tx_valid) begin
                tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                miso_q   <= tx_data[DATA_W-1];
                tx_cnt   <= TXC_W'(1);
              end
            end else if (tx_cnt < TXC_W'(DATA_W)) begin
              miso_q   <= tx_shift[DATA_W-1];
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              tx_cnt   <= tx_cnt + TXC_W'(1);
            end else if (tx_cnt == TXC_W'(DATA_W)) begin
              miso_q <= 1'b0;
              tx_cnt <= tx_cnt + TXC_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - directed bench for spi_slave_param (DATA_W=8 and DATA_W=16 instances).
// Parity steps run only when SPI_SLAVE_PARITY_EN is defined.
module tb_spi_slave_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ss_n, mosi, tx_valid;
  logic [7:0]  tx_data;
  logic        miso, rx_valid, busy, frame_err, parity_err;
  logic [9:0]  rx_data;

  logic        ss16, mosi16, tx_valid16;
  logic [15:0] tx_data16;
  logic        miso16, rx_valid16, busy16, frame_err16, parity_err16;
  logic [17:0] rx_data16;

  int total = 0;
  int bad   = 0;

  spi_slave_param #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy), .frame_err(frame_err), .parity_err(parity_err)
  );

  spi_slave_param #(.DATA_W(16)) dut16 (
    .clk(clk), .rst(rst), .SS_n(ss16), .MOSI(mosi16), .MISO(miso16),
    .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_data(tx_data16), .tx_valid(tx_valid16),
    .busy(busy16), .frame_err(frame_err16), .parity_err(parity_err16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Select, then shift the top n bits of f MSB first.
  task automatic send_bits(input logic [9:0] f, input int n);
    ss_n = 1'b0;
    tick();
    check("busy_start", busy, 1);
    for (int i = 9; i > 9 - n; i--) begin
      mosi = f[i];
      tick();
      check("busy_frame", busy, 1);
    end
  endtask

  task automatic send_frame(input logic [9:0] f, input bit flip);
    send_bits(f, 10);
`ifdef SPI_SLAVE_PARITY_EN
    mosi = (~^f) ^ flip;
    tick();
`else
    if (flip) $display("note: parity flip ignored without parity build");
`endif
  endtask

  task automatic deselect();
    ss_n = 1'b1;
    tick();
  endtask

  logic [7:0]  exp_bits;
  logic [17:0] f16;

  initial begin
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    ss16 = 1'b1; mosi16 = 1'b0; tx_valid16 = 1'b0; tx_data16 = 16'h0000;
    tick(); tick();
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_miso", miso, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_flag", dut.rd_addr_flag, 0);
    check("rst_busy16", busy16, 0);
    rst = 1'b0;
    tick();

    // write frame 00_1010_0101
    send_frame(10'h0A5, 1'b0);
    check("wr_rx_valid", rx_valid, 1);
    check("wr_rx_data", rx_data, 10'h0A5);
    check("wr_parity_err", parity_err, 0);
    tick();
    check("wr_valid_once", rx_valid, 0);
    mosi = 1'b1;
    repeat (3) tick();
    check("wr_extra_valid", rx_valid, 0);
    check("wr_extra_hold", rx_data, 10'h0A5);
    check("wr_extra_busy", busy, 1);
    deselect();
    check("wr_end_busy", busy, 0);
    check("wr_end_ferr", frame_err, 0);

    // read-address then read-data with readout of C3
    send_frame(10'h23C, 1'b0);
    check("ra_rx_data", rx_data, 10'h23C);
    check("ra_rx_valid", rx_valid, 1);
    check("ra_flag", dut.rd_addr_flag, 1);
    deselect();
    send_frame(10'h300, 1'b0);
    check("rd_rx_data", rx_data, 10'h300);
    check("rd_rx_valid", rx_valid, 1);
    check("rd_flag", dut.rd_addr_flag, 0);
    check("rd_miso_idle", miso, 0);
    tick();
    check("rd_wait_miso", miso, 0);
    tx_data = 8'hC3; tx_valid = 1'b1;
    exp_bits = 8'b1100_0011;
    for (int i = 7; i >= 0; i--) begin
      tick();
      check("rd_miso_bit", miso, exp_bits[i]);
    end
    tx_data = 8'hFF;
    tick();
    check("rd_miso_after", miso, 0);
    tick(); tick();
    check("rd_miso_ignore", miso, 0);
    tx_valid = 1'b0;
    deselect();
    check("rd_end_ferr", frame_err, 0);
    check("rd_end_busy", busy, 0);

    // abort mid read-data frame keeps rd_addr_flag set
    send_frame(10'h23C, 1'b0);
    deselect();
    send_bits(10'h300, 3);
    deselect();
    check("abrd_ferr", frame_err, 1);
    check("abrd_valid", rx_valid, 0);
    check("abrd_busy", busy, 0);
    check("abrd_flag", dut.rd_addr_flag, 1);
    tick();
    check("abrd_ferr_once", frame_err, 0);
    // complete read-data frame, then abort while awaiting tx_valid
    send_frame(10'h300, 1'b0);
    check("abwait_flag", dut.rd_addr_flag, 0);
    tick();
    deselect();
    check("abwait_ferr", frame_err, 1);
    tick();

    // write frame aborted after 5 bits, then a full frame
    send_bits(10'h15A, 5);
    deselect();
    check("abwr_ferr", frame_err, 1);
    check("abwr_valid", rx_valid, 0);
    check("abwr_busy", busy, 0);
    check("abwr_hold", rx_data, 10'h300);
    tick();
    send_frame(10'h15A, 1'b0);
    check("abwr_next_data", rx_data, 10'h15A);
    check("abwr_next_valid", rx_valid, 1);
    check("abwr_next_ferr", frame_err, 0);
    deselect();

    // reset during readout bit 4 of 8'h5A
    send_frame(10'h23C, 1'b0);
    deselect();
    send_frame(10'h300, 1'b0);
    tx_data = 8'h5A; tx_valid = 1'b1;
    tick(); check("rst_rd_b7", miso, 0);
    tick(); check("rst_rd_b6", miso, 1);
    tick(); check("rst_rd_b5", miso, 0);
    tick(); check("rst_rd_b4", miso, 1);
    rst = 1'b1; ss_n = 1'b1; tx_valid = 1'b0;
    tick();
    check("rst_rd_miso", miso, 0);
    check("rst_rd_busy", busy, 0);
    check("rst_rd_data", rx_data, 0);
    check("rst_rd_valid", rx_valid, 0);
    check("rst_rd_ferr", frame_err, 0);
    check("rst_rd_flag", dut.rd_addr_flag, 0);
    rst = 1'b0;
    tick();
    check("rst_rd_ferr2", frame_err, 0);

`ifdef SPI_SLAVE_PARITY_EN
    send_frame(10'h0F0, 1'b0);
    check("par_ok_valid", rx_valid, 1);
    check("par_ok_err", parity_err, 0);
    deselect();
    send_frame(10'h0F0, 1'b1);
    check("par_bad_valid", rx_valid, 0);
    check("par_bad_err", parity_err, 1);
    tick();
    check("par_bad_once", parity_err, 0);
    deselect();
`endif

    // DATA_W=16 write frame 01_A5C3
    f16 = 18'h1A5C3;
    ss16 = 1'b0;
    tick();
    for (int i = 17; i >= 0; i--) begin
      mosi16 = f16[i];
      tick();
    end
`ifdef SPI_SLAVE_PARITY_EN
    mosi16 = ~^f16;
    tick();
`endif
    check("w16_rx_data", rx_data16, 18'h1A5C3);
    check("w16_rx_valid", rx_valid16, 1);
    check("w16_busy", busy16, 1);
    check("w16_miso", miso16, 0);
    check("w16_perr", parity_err16, 0);
    ss16 = 1'b1;
    tick();
    check("w16_ferr", frame_err16, 0);
    check("w16_idle", busy16, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
